fifo_access_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port FIFO (wnr/en command interface, full/empty flags) among NUM_REQ requesters, each issuing a write (push) or read (pop).
- Drives the FIFO command port with registered outputs, at most one operation per cycle.
- Keeps a shadow occupancy count so eligibility never depends on the FIFO's lagging flags.
- Returns read data tagged with the requester ID.

---
 rtl/fifo_access_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_access_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_access_arbiter.sv
// Round-robin arbiter sharing one single-port FIFO among NUM_REQ push/pop requesters; optional SHADOW_CHECK_EN flag cross-check.
// Latency: req -> ack/FIFO command 1 cycle, read data tagged with requester id 2 cycles after the winning cycle.
// Backpressure: a shadow occupancy count masks writes when full and reads when empty; masked requesters simply wait.
module fifo_access_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int BUS_WIDTH  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_wnr,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           fifo_en,
    output logic                           fifo_wnr,
    output logic [BUS_WIDTH-1:0]           fifo_in,
    input  logic [BUS_WIDTH-1:0]           fifo_out,
    input  logic                           fifo_full,
    input  logic                           fifo_empty,
    output logic                           rd_valid,
    output logic [ID_WIDTH-1:0]            rd_id,
    output logic [BUS_WIDTH-1:0]           rd_data,
    output logic [CNT_WIDTH-1:0]           count,
    output logic                           err
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);

    logic [ID_WIDTH-1:0]  rr_ptr;
    logic [ID_WIDTH-1:0]  iss_id;
    logic [BUS_WIDTH-1:0] rd_hold;
    logic [NUM_REQ-1:0]   elig;
    logic                 can_wr;
    logic                 can_rd;
    logic                 win_vld;
    logic [ID_WIDTH-1:0]  win_id;
    logic [ID_WIDTH-1:0]  ptr_nxt;
    logic                 win_wnr;
    logic [BUS_WIDTH-1:0] win_dat;

    assign can_wr = (count < DEPTH_C);
    assign can_rd = (count != '0);

    // A requester whose ack is currently visible is skipped so a held req is not re-granted on the same request.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req[i] & ~ack[i] & (req_wnr[i] ? can_wr : can_rd);
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!win_vld && elig[ID_WIDTH'(idx)]) begin
                win_vld = 1'b1;
                win_id  = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        win_wnr = 1'b0;
        win_dat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_WIDTH'(i)) begin
                win_wnr = req_wnr[i];
                win_dat = req_data[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    assign ptr_nxt = (win_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : win_id + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ack      <= '0;
            fifo_en  <= 1'b0;
            fifo_wnr <= 1'b0;
            fifo_in  <= '0;
            rr_ptr   <= '0;
            iss_id   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_id    <= '0;
            rd_hold  <= '0;
        end else begin
            ack      <= '0;
            fifo_en  <= 1'b0;
            fifo_wnr <= 1'b0;
            fifo_in  <= '0;
            if (win_vld) begin
                ack[win_id] <= 1'b1;
                fifo_en     <= 1'b1;
                fifo_wnr    <= win_wnr;
                fifo_in     <= win_wnr ? win_dat : '0;
                iss_id      <= win_id;
                rr_ptr      <= ptr_nxt;
                count       <= win_wnr ? count + 1'b1 : count - 1'b1;
            end
            // The FIFO pops at the end of the issue cycle, so its registered output is valid one cycle later.
            rd_valid <= fifo_en & ~fifo_wnr;
            if (fifo_en && !fifo_wnr) begin
                rd_id <= iss_id;
            end
            if (rd_valid) begin
                rd_hold <= fifo_out;
            end
        end
    end

    assign rd_data = rd_valid ? fifo_out : rd_hold;

`ifdef SHADOW_CHECK_EN
    logic shadow_bad;

    // Only compare on idle cycles: an in-flight op has already moved count but not yet the FIFO flags.
    assign shadow_bad = ~fifo_en & ((fifo_full  != (count == DEPTH_C)) |
                                    (fifo_empty != (count == '0)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (shadow_bad) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_flags;

    assign unused_flags = fifo_full ^ fifo_empty;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Randomized and directed bench for fifo_access_arbiter against a behavioural arbiter/FIFO reference model.
module tb_fifo_access_arbiter;

    localparam int N = 4;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_wnr;
    logic [15:0] req_data;
    logic [3:0]  ack;
    logic        fifo_en, fifo_wnr;
    logic [3:0]  fifo_in, fifo_out;
    logic        fifo_full, fifo_empty;
    logic        rd_valid;
    logic [1:0]  rd_id;
    logic [3:0]  rd_data;
    logic [3:0]  count;
    logic        err;

    int vecs  = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    fifo_access_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_wnr(req_wnr), .req_data(req_data),
        .ack(ack), .fifo_en(fifo_en), .fifo_wnr(fifo_wnr), .fifo_in(fifo_in),
        .fifo_out(fifo_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data), .count(count), .err(err)
    );

    // Behavioural single-port FIFO with registered read output.
    logic [3:0] fq[$];
    int         fcnt = 0;
    logic       bad_empty = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            fq.delete();
            fifo_out <= '0;
        end else if (fifo_en) begin
            if (fifo_wnr) fq.push_back(fifo_in);
            else if (fq.size() > 0) fifo_out <= fq.pop_front();
        end
        fcnt <= fq.size();
    end

    assign fifo_full  = (fcnt == D);
    assign fifo_empty = (fcnt == 0) ^ bad_empty;

    // Reference model state: what the outputs should be in the current cycle.
    int         m_ptr = 0, m_cnt = 0, m_iss = 0;
    logic [3:0] m_ack = '0, m_in = '0, m_rdd = '0, m_pend = '0;
    logic       m_en = 1'b0, m_wnr = 1'b0, m_rdv = 1'b0, m_err = 1'b0;
    logic [1:0] m_rdid = '0;
    logic [3:0] exp_q[$];

    function automatic logic [21:0] exp_vec();
        return {m_ack, m_en, m_wnr, m_in, m_rdv, m_rdid, m_rdd, 4'(m_cnt), m_err};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {ack, fifo_en, fifo_wnr, fifo_in, rd_valid, rd_id, rd_data, count, err};
    endfunction

    task automatic tick();
        int         w;
        logic       rst_s, nerr, rdv_n, wr;
        logic [3:0] wd;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (w < 0 && req[i[1:0]] && !m_ack[i[1:0]] &&
                (req_wnr[i[1:0]] ? (m_cnt < D) : (m_cnt > 0))) w = i;
        end
        wr = (w >= 0) ? req_wnr[w[1:0]] : 1'b0;
        wd = (w >= 0) ? 4'(req_data >> (w * 4)) : 4'h0;
        nerr = m_err;
`ifdef SHADOW_CHECK_EN
        if (!m_en && ((fifo_full != (m_cnt == D)) || (fifo_empty != (m_cnt == 0)))) nerr = 1'b1;
`endif
        rdv_n = m_en && !m_wnr;
        rst_s = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_s) begin
            m_ptr = 0; m_cnt = 0; m_iss = 0; m_ack = '0; m_in = '0; m_rdd = '0;
            m_en = 0; m_wnr = 0; m_rdv = 0; m_err = 0; m_rdid = '0;
            exp_q.delete();
        end else begin
            if (rdv_n) begin
                m_rdid = 2'(m_iss);
                m_rdd  = m_pend;
            end
            m_rdv = rdv_n;
            m_err = nerr;
            m_ack = '0; m_en = 0; m_wnr = 0; m_in = '0;
            if (w >= 0) begin
                m_ack = 4'(1 << w);
                m_en  = 1'b1;
                m_wnr = wr;
                m_iss = w;
                m_ptr = (w + 1) % N;
                if (wr) begin
                    m_in = wd;
                    exp_q.push_back(wd);
                    m_cnt++;
                end else begin
                    m_pend = exp_q.pop_front();
                    m_cnt--;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; req_wnr = '0; req_data = '0; bad_empty = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if (dut_vec() !== 22'h0) begin
            fails++;
            $display("FAIL reset_zero cyc=%0d got=%h exp=%h", cyc, dut_vec(), 22'h0);
        end
        tick();
        vecs++;
        if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
        end
    endtask

    task automatic test_single_write();
        do_reset();
        req = 4'b0001; req_wnr = 4'b0001; req_data = 16'h000A;
        tick();
        vecs++;
        if ({ack, fifo_en, fifo_wnr, fifo_in, count} !== {4'b0001, 1'b1, 1'b1, 4'hA, 4'd1}) begin
            fails++;
            $display("FAIL single_write cyc=%0d got=%h exp=%h", cyc,
                     {ack, fifo_en, fifo_wnr, fifo_in, count}, {4'b0001, 1'b1, 1'b1, 4'hA, 4'd1});
        end
        req = '0;
        tick();
        vecs++;
        if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL single_write_after cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [10] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
        do_reset();
        req = 4'b1111; req_wnr = 4'b1111; req_data = 16'h4321;
        for (int c = 0; c < 10; c++) begin
            tick();
            vecs++;
            if (ack !== seq[c] || fifo_en !== (seq[c] != 4'h0)) begin
                fails++;
                $display("FAIL rr_ack cyc=%0d step=%0d got=%b/%b exp=%b", cyc, c, ack, fifo_en, seq[c]);
            end
            vecs++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL rr_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        vecs++;
        if (count !== 4'd8) begin
            fails++;
            $display("FAIL rr_full_count cyc=%0d got=%0d exp=8", cyc, count);
        end
    endtask

    task automatic test_reads();
        do_reset();
        req_wnr = 4'b0011; req_data = 16'h0073; req = 4'b0011;
        tick(); req[0] = 1'b0;
        tick(); req = '0;
        tick();
        req_wnr = '0;
        for (int r = 0; r < 2; r++) begin
            req = 4'b0100;
            tick();
            vecs++;
            if (ack !== 4'b0100 || count !== 4'(1 - r)) begin
                fails++;
                $display("FAIL rd_issue cyc=%0d got=%b/%0d exp=0100/%0d", cyc, ack, count, 1 - r);
            end
            req = '0;
            tick();
            vecs++;
            if ({rd_valid, rd_id, rd_data} !== {1'b1, 2'd2, (r == 0) ? 4'h3 : 4'h7}) begin
                fails++;
                $display("FAIL rd_return cyc=%0d got=%h exp=%h", cyc, {rd_valid, rd_id, rd_data},
                         {1'b1, 2'd2, (r == 0) ? 4'h3 : 4'h7});
            end
            vecs++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL rd_model cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        req = 4'b0100;
        tick();
        tick();
        vecs++;
        if (ack !== 4'b0000 || fifo_en !== 1'b0 || rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL rd_empty_mask cyc=%0d got=%b/%b/%b exp=0000/0/0", cyc, ack, fifo_en, rd_valid);
        end
        req = '0;
    endtask

    task automatic test_full_priority();
        bool_loop: begin end
        do_reset();
        req = 4'b1111; req_wnr = 4'b1111; req_data = 16'h9876;
        for (int c = 0; c < 20 && m_cnt < D; c++) tick();
        req = 4'b0011; req_wnr = 4'b0001;
        tick();
        vecs++;
        if (ack !== 4'b0010 || count !== 4'd7) begin
            fails++;
            $display("FAIL full_read_first cyc=%0d got=%b/%0d exp=0010/7", cyc, ack, count);
        end
        req[1] = 1'b0;
        for (int c = 0; c < 4 && ack !== 4'b0001; c++) tick();
        vecs++;
        if (ack !== 4'b0001 || count !== 4'd8) begin
            fails++;
            $display("FAIL full_write_later cyc=%0d got=%b/%0d exp=0001/8", cyc, ack, count);
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0001; req_wnr = 4'b0001; req_data = 16'h0005;
        tick(); req = '0;
        tick();
        req = 4'b0100; req_wnr = '0;
        tick(); req = '0;
        rst = 1'b0;
        tick();
        vecs++;
        if (dut_vec() !== 22'h0) begin
            fails++;
            $display("FAIL mid_reset cyc=%0d got=%h exp=%h", cyc, dut_vec(), 22'h0);
        end
        rst = 1'b1;
        tick();
        vecs++;
        if (rd_valid !== 1'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset_norv cyc=%0d got=%b/%0d exp=0/0", cyc, rd_valid, count);
        end
        req = 4'b1111; req_wnr = 4'b1111;
        tick();
        vecs++;
        if (ack !== 4'b0001) begin
            fails++;
            $display("FAIL mid_reset_ptr cyc=%0d got=%b exp=0001", cyc, ack);
        end
        req = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && ack[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i]              = 1'b1;
                    req_wnr[i]          = 1'($urandom_range(0, 1));
                    req_data[i*4 +: 4]  = 4'($urandom);
                end
            end
            if (req == 4'hF && ((req_wnr == 4'h0 && m_cnt == 0) || (req_wnr == 4'hF && m_cnt == D)))
                req = '0;
            tick();
            vecs++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
            end
        end
        req = '0;
    endtask

    task automatic test_shadow();
        do_reset();
        tick();
        bad_empty = 1'b1;
        tick();
        bad_empty = 1'b0;
        vecs++;
        if (err !== m_err) begin
            fails++;
            $display("FAIL shadow_set cyc=%0d got=%b exp=%b", cyc, err, m_err);
        end
        tick();
        tick();
        vecs++;
        if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL shadow_sticky cyc=%0d got=%h exp=%h", cyc, dut_vec(), exp_vec());
        end
        rst = 1'b0;
        tick();
        vecs++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL shadow_clear cyc=%0d got=%b exp=0", cyc, err);
        end
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req = '0; req_wnr = '0; req_data = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_reads();
        test_full_priority();
        test_reset_mid();
        test_random();
        test_shadow();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
